// File: rtl/instr_fetch_mem_if.sv
// Fetch-side bus of the instruction memory: request, response, redirect flush and preload port.
// The fetch controller takes the master modport; the memory takes the slave modport.
interface instr_fetch_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        rsp_err;
  logic              load_en;
  logic [IDX_W-1:0]  load_addr;
  logic [DATA_W-1:0] load_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Clocked instruction memory: one-cycle read stage feeding a small response FIFO,
// with redirect flush, preload write port and misaligned/out-of-range error tagging.
module instr_fetch_mem #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             rst_n,
  instr_fetch_mem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              inflight;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_addr;
  logic [1:0]        if_err;

  logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [1:0]        fifo_err   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [1:0]        req_err;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              pop_raw;
  logic              pop;
  logic              push;
  logic [CNT_W:0]    occupancy;

  // Out of range whenever any index bit above the memory size is set; DEPTH is a power of two.
  assign req_err[0] = |bus.req_addr[1:0];
  assign req_err[1] = |bus.req_addr[ADDR_W-1:IDX_W+2];
  assign req_idx    = bus.req_addr[IDX_W+1:2];

  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_instr = fifo_instr[rd_ptr];
  assign bus.rsp_addr  = fifo_addr[rd_ptr];
  assign bus.rsp_err   = fifo_err[rd_ptr];

  // Counting this cycle's pop lets a full FIFO still accept one fetch per cycle.
  assign pop_raw       = bus.rsp_valid && bus.rsp_ready;
  assign occupancy     = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop_raw);
  assign bus.req_ready = (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  assign accept = bus.req_valid && bus.req_ready;
  assign pop    = pop_raw && !bus.flush;
  assign push   = inflight && !bus.flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Array storage is not reset; non-blocking write gives old data on a same-word read.
  always_ff @(posedge clk) begin
    if (bus.load_en) mem[bus.load_addr] <= bus.load_data;
    if (accept) if_instr <= (req_err != 2'b00) ? '0 : mem[req_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      if_addr  <= '0;
      if_err   <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        if_addr <= bus.req_addr;
        if_err  <= req_err;
      end
    end
  end

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_addr[i]  <= '0;
        fifo_err[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= if_instr;
        fifo_addr[wr_ptr]  <= if_addr;
        fifo_err[wr_ptr]   <= if_err;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_mem;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int FD     = 2;
  localparam int IW     = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   edges = 0;

  instr_fetch_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  instr_fetch_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: every outstanding request is one queue entry, visible two edges after acceptance.
  typedef struct {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic [1:0]        e;
    int                vis;
  } ent_t;

  ent_t              mq[$];
  logic [DATA_W-1:0] mem_m [DEPTH];

  always @(negedge clk) begin : model
    bit   m_valid;
    bit   m_pop;
    bit   m_ready;
    ent_t n;
    if (!rst_n) begin
      mq.delete();
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
      chk("rst_rsp_instr", 64'(bus.rsp_instr), 64'(0));
    end else begin
      m_valid = (mq.size() != 0) && (mq[0].vis <= edges);
      m_pop   = m_valid && bus.rsp_ready;
      m_ready = (mq.size() - int'(m_pop)) < FD;
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      chk("req_ready", 64'(bus.req_ready), 64'(m_ready));
      if (m_valid) begin
        chk("rsp_instr", 64'(bus.rsp_instr), 64'(mq[0].d));
        chk("rsp_addr", 64'(bus.rsp_addr), 64'(mq[0].a));
        chk("rsp_err", 64'(bus.rsp_err), 64'(mq[0].e));
      end
      if (bus.flush) mq.delete();
      else if (m_pop) void'(mq.pop_front());
      if (bus.req_valid && m_ready) begin
        n.a   = bus.req_addr;
        n.e   = {((bus.req_addr >> 2) >= 32'(DEPTH)), (bus.req_addr % 4) != 0};
        n.d   = (n.e != 2'b00) ? '0 : mem_m[bus.req_addr[IW+1:2]];
        n.vis = edges + 2;
        mq.push_back(n);
      end
      if (bus.load_en) mem_m[bus.load_addr] = bus.load_data;
    end
  end

  logic [ADDR_W-1:0] req_q[$];
  logic [DATA_W-1:0] got_i[$];
  logic [ADDR_W-1:0] got_a[$];
  logic [1:0]        got_e[$];
  int                got_c[$];
  int                acc_c[$];

  task automatic clr();
    got_i.delete(); got_a.delete(); got_e.delete(); got_c.delete(); acc_c.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue queued addresses in order for n cycles, recording accepts and consumed responses.
  task automatic run(input int n);
    bit acc;
    for (int c = 0; c < n; c++) begin
      bus.req_valid = (req_q.size() != 0);
      bus.req_addr  = (req_q.size() != 0) ? req_q[0] : '0;
      @(negedge clk);
      acc = bus.req_valid && bus.req_ready;
      if (acc) acc_c.push_back(c);
      if (bus.rsp_valid && bus.rsp_ready) begin
        got_i.push_back(bus.rsp_instr);
        got_a.push_back(bus.rsp_addr);
        got_e.push_back(bus.rsp_err);
        got_c.push_back(c);
      end
      step();
      if (acc) void'(req_q.pop_front());
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
  endtask

  logic [DATA_W-1:0] exp4 [4];
  logic [ADDR_W-1:0] ea [3];
  logic [1:0]        ee [3];

  initial begin
    bus.req_valid = 0; bus.req_addr = '0; bus.flush = 0; bus.rsp_ready = 0;
    bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
    exp4 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    ea   = '{32'h6, 32'h1000, 32'h1002};
    ee   = '{2'b01, 2'b10, 2'b11};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_ready", 64'(bus.req_ready), 64'(1));
    chk("reset_addr", 64'(bus.rsp_addr), 64'(0));
    chk("reset_err", 64'(bus.rsp_err), 64'(0));
    rst_n = 1'b1;

    // Preload everything so no read returns X, then the known words.
    for (int i = 0; i < DEPTH + 4; i++) begin
      bus.load_en   = 1'b1;
      bus.load_addr = IW'(i % DEPTH);
      bus.load_data = (i < DEPTH) ? 32'($urandom) : exp4[i - DEPTH];
      step();
    end
    bus.load_en = 1'b0;

    // Preload and stream
    clr(); bus.rsp_ready = 1'b1;
    req_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    run(8);
    chk("stream_count", 64'(got_i.size()), 64'(4));
    for (int i = 0; i < 4; i++) if (i < got_i.size()) begin
      chk("stream_instr", 64'(got_i[i]), 64'(exp4[i]));
      chk("stream_addr", 64'(got_a[i]), 64'(4 * i));
      chk("stream_err", 64'(got_e[i]), 64'(0));
      if (i > 0) chk("stream_gap", 64'(got_c[i] - got_c[i-1]), 64'(1));
    end
    if (got_c.size() > 0 && acc_c.size() > 0)
      chk("stream_latency", 64'(got_c[0] - acc_c[0]), 64'(2));

    // Back-pressure
    clr(); bus.rsp_ready = 1'b0;
    req_q = '{32'h0, 32'h4, 32'h8};
    run(5);
    chk("bp_accepts", 64'(acc_c.size()), 64'(2));
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_head_valid", 64'(bus.rsp_valid), 64'(1));
    chk("bp_head_instr", 64'(bus.rsp_instr), 64'(32'h11111111));
    step();
    clr(); bus.rsp_ready = 1'b1;
    run(6);
    chk("bp_count", 64'(got_i.size()), 64'(3));
    for (int i = 0; i < 3; i++) if (i < got_i.size())
      chk("bp_instr", 64'(got_i[i]), 64'(exp4[i]));

    // Error responses
    clr();
    req_q = '{32'h6, 32'h1000, 32'h1002};
    run(6);
    chk("err_count", 64'(got_i.size()), 64'(3));
    for (int i = 0; i < 3; i++) if (i < got_i.size()) begin
      chk("err_bits", 64'(got_e[i]), 64'(ee[i]));
      chk("err_instr", 64'(got_i[i]), 64'(0));
      chk("err_addr", 64'(got_a[i]), 64'(ea[i]));
    end

    // Flush with two responses buffered and a redirect request in the same cycle
    clr(); bus.rsp_ready = 1'b0;
    req_q = '{32'h0, 32'h4};
    run(4);
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h8; bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid_before", 64'(bus.rsp_valid), 64'(1));
    chk("flush_ready", 64'(bus.req_ready), 64'(1));
    step();
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty", 64'(bus.rsp_valid), 64'(0));
    @(negedge clk);
    chk("flush_next_valid", 64'(bus.rsp_valid), 64'(1));
    chk("flush_next_instr", 64'(bus.rsp_instr), 64'(32'h33333333));
    chk("flush_next_addr", 64'(bus.rsp_addr), 64'(32'h8));
    @(negedge clk);
    chk("flush_drained", 64'(bus.rsp_valid), 64'(0));
    step();

    // Load/read collision on word 1
    bus.req_valid = 1'b1; bus.req_addr = 32'h4;
    bus.load_en = 1'b1; bus.load_addr = IW'(1); bus.load_data = 32'hAAAAAAAA;
    step();
    bus.req_valid = 1'b0; bus.load_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("coll_old_valid", 64'(bus.rsp_valid), 64'(1));
    chk("coll_old_instr", 64'(bus.rsp_instr), 64'(32'h22222222));
    step();
    clr();
    req_q = '{32'h4};
    run(4);
    chk("coll_new_count", 64'(got_i.size()), 64'(1));
    if (got_i.size() > 0) chk("coll_new_instr", 64'(got_i[0]), 64'(32'hAAAAAAAA));

    // Reset in mid-stream with two responses pending
    clr(); bus.rsp_ready = 1'b0;
    req_q = '{32'h0, 32'hC};
    run(4);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.rsp_valid), 64'(0));
    chk("midrst_ready", 64'(bus.req_ready), 64'(1));
    chk("midrst_instr", 64'(bus.rsp_instr), 64'(0));
    chk("midrst_addr", 64'(bus.rsp_addr), 64'(0));
    chk("midrst_err", 64'(bus.rsp_err), 64'(0));
    @(posedge clk);
    step();
    rst_n = 1'b1;
    clr(); bus.rsp_ready = 1'b1;
    run(6);
    chk("midrst_no_stale", 64'(got_i.size()), 64'(0));

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0: bus.req_addr = 32'($urandom_range(0, 4 * DEPTH - 1));
        1: bus.req_addr = 32'($urandom);
        2: bus.req_addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
        default: bus.req_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.load_en   = ($urandom_range(0, 4) == 0);
      bus.load_addr = IW'($urandom_range(0, DEPTH - 1));
      bus.load_data = 32'($urandom);
      step();
    end
    bus.req_valid = 1'b0; bus.flush = 1'b0; bus.load_en = 1'b0; bus.rsp_ready = 1'b1;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised, clocked instruction memory for the instruction fetch stage. It replaces the combinational word-lookup memory with a request/response interface:
- one-cycle synchronous read
- a small response FIFO for back-pressure
- a flush for branch redirects
- a load port for program preload
- misalignment and out-of-range error reporting

It sits between the PC/fetch control logic and the IF/ID pipeline register.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- ADDR_W, 32, byte-address width
- DEPTH, 1024, memory size in words; power of two, at least 2
- FIFO_DEPTH, 2, response FIFO entries; at least 2

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_addr  in  ADDR_W  byte address of the instruction
- flush  in  1  discard all in-flight and buffered responses
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_instr  out  DATA_W  fetched instruction
- rsp_addr  out  ADDR_W  byte address that produced rsp_instr
- rsp_err  out  2  bit0 = misaligned, bit1 = out of range
- load_en  in  1  write one word
- load_addr  in  clog2(DEPTH)  word index for the write
- load_data  in  DATA_W  word to write

## Operation
- **Word index:** WI = req_addr >> 2.
  - Misaligned when req_addr[1:0] != 0.
  - Out of range when WI >= DEPTH, judged on the full ADDR_W-2 bit index with no truncation or wrap.
- **Request acceptance:** a request is accepted when req_valid && req_ready.
  - The memory read is registered at the accepting edge; this is the in-flight stage, with an inflight flag of 1 bit.
  - The following edge pushes the result {instr, addr, err} into the FIFO.
- **Error responses:** if either error bit is set, rsp_instr = 0 and the memory is not read. Both bits may be set together.
- **req_ready** = (count + inflight − pop) < FIFO_DEPTH, where pop = rsp_valid && rsp_ready.
  - This is a combinational path from rsp_ready to req_ready, and it is intentional: it sustains one fetch per cycle.
- **Response outputs:** rsp_valid = (count != 0). rsp_instr, rsp_addr and rsp_err always show the FIFO head.
- **FIFO ordering:** strict FIFO; responses return in request order.
- **Flush**, effective at the edge where it is high:
  - Clears count and inflight, and cancels any pop that cycle.
  - A request accepted in the flush cycle is kept: it becomes the sole in-flight read (the redirect target).
  - req_ready in a flush cycle equals its normal value.
- **Load port:** on load_en, at the edge, mem[load_addr] = load_data.
  - A read and a load of the same word on the same edge returns the old data.
  - Loads are legal at any time, independent of the handshake.
- **Memory contents:** not reset. Reads of unloaded words return X in simulation, with no error flag.

## Timing
- **Reset (rst_n low, asynchronous):**
  - count = 0, inflight = 0, FIFO pointers = 0.
  - rsp_valid = 0, rsp_instr = 0, rsp_addr = 0, rsp_err = 0.
  - req_ready = 1 as soon as reset asserts.
- **Reset deassertion:** takes effect on the next rising edge. A reset in mid-operation drops all outstanding work silently; no response is produced for any request outstanding at reset.
- **Latency:** a request accepted at edge N produces rsp_valid = 1 in the cycle after edge N+1, provided the FIFO was empty and no flush occurred.
- **Throughput:** one response per cycle with rsp_ready held high. No bubbles after the first.
- **Back-pressure:**
  - While rsp_ready = 0, the FIFO fills to FIFO_DEPTH including the in-flight entry, then req_ready = 0.
  - Head outputs stay stable while rsp_valid && !rsp_ready.
- **Simultaneous events:**
  - Push and pop on the same edge leave count unchanged.
  - Flush overrides both push and pop.
  - Load overrides nothing.
- **Pointer wrap:** FIFO pointers wrap modulo FIFO_DEPTH; count has clog2(FIFO_DEPTH+1) bits.

## Test plan
- **Preload and stream:**
  - Stimulus: load mem[0..3] = 0x11111111, 0x22222222, 0x33333333, 0x44444444; issue addresses 0x0, 0x4, 0x8, 0xC back to back with rsp_ready = 1.
  - Required: four responses in order on consecutive cycles. The first arrives 2 cycles after the first accept. rsp_err = 0.
- **Back-pressure:**
  - Stimulus: rsp_ready = 0; req_valid held with addresses 0x0, 0x4, 0x8; release after 5 cycles.
  - Required: req_ready drops after 2 accepts (FIFO_DEPTH = 2); head holds 0x11111111 stable; then 0x22222222 and 0x33333333 follow without loss or duplication.
- **Errors:**
  - Stimulus: request 0x6, 0x1000 and 0x1002 (DEPTH = 1024).
  - Required: rsp_err = 01, 10 and 11 respectively; rsp_instr = 0; rsp_addr echoes each address.
- **Flush:**
  - Stimulus: with 2 responses buffered, assert flush together with a request at 0x8.
  - Required: the buffered entries vanish; the next response is 0x33333333 at 0x8.
- **Load/read collision:**
  - Stimulus: load mem[1] = 0xAAAAAAAA on the same edge that accepts a read of 0x4.
  - Required: rsp_instr = 0x22222222; a following read of 0x4 returns 0xAAAAAAAA.
- **Reset mid-stream:**
  - Stimulus: pulse rst_n low asynchronously while 2 responses are pending.
  - Required: rsp_valid = 0 and outputs = 0 immediately; req_ready = 1; no stale response appears after reset is released.
